// File: rtl/therm_pkg.sv
// Shared definitions for the thermometer datapath: drain FSM states and
// default data / counter widths.
package therm_pkg;

    localparam int DEFAULT_DW = 7;
    localparam int DEFAULT_CW = 15;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_DONE = 2'd2
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin write arbiter. The grant is combinational, gated by the
// FIFO full flag, and alternates on ties using the registered last-grant pointer.
module rr_arbiter2
    import therm_pkg::*;
#(
    parameter int DW = DEFAULT_DW
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [DW:0] req0_data,
    input  logic [DW:0] req1_data,
    input  logic        full,
    output logic        gnt0,
    output logic        gnt1,
    output logic        write,
    output logic [DW:0] wr_data
);

    // 0: req0 was granted last, 1: req1 was granted last
    logic last_reg;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!full) begin
            if (req0 && req1) begin
                gnt0 = last_reg;
                gnt1 = !last_reg;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    assign write = gnt0 | gnt1;

    always_comb begin
        wr_data = '0;
        if (gnt0) begin
            wr_data = req0_data;
        end else if (gnt1) begin
            wr_data = req1_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_reg <= 1'b1;
        end else if (gnt0) begin
            last_reg <= 1'b0;
        end else if (gnt1) begin
            last_reg <= 1'b1;
        end
    end

endmodule

// File: rtl/fifo_scheduler.sv
// Sample FIFO controller: round-robin producer writes into the FIFO and a
// start/done drain of FIFO bytes into the UART transmitter.
module fifo_scheduler
    import therm_pkg::*;
#(
    parameter int DW = DEFAULT_DW,
    parameter int CW = DEFAULT_CW
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [DW:0] req0_data,
    input  logic [DW:0] req1_data,
    output logic        gnt0,
    output logic        gnt1,
    output logic        fifo_write,
    output logic [DW:0] fifo_wr_data,
    input  logic        fifo_full,
    output logic        fifo_read,
    input  logic [DW:0] fifo_rd_data,
    input  logic        fifo_empty,
    input  logic        drain_en,
    output logic        tx_start,
    output logic [DW:0] tx_data,
    input  logic        tx_done,
    output logic        tx_active,
    output logic [CW:0] sent_count
);

    sched_state_t state_reg;
    logic         tx_start_reg;
    logic         tx_active_reg;
    logic [DW:0]  tx_data_reg;
    logic [CW:0]  sent_count_reg;

    rr_arbiter2 #(
        .DW(DW)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .req0_data (req0_data),
        .req1_data (req1_data),
        .full      (fifo_full),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .write     (fifo_write),
        .wr_data   (fifo_wr_data)
    );

    // Strobes are registered alongside the state, so tx_start/fifo_read are
    // high exactly for the single SEND cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            tx_start_reg   <= 1'b0;
            tx_active_reg  <= 1'b0;
            tx_data_reg    <= '0;
            sent_count_reg <= '0;
        end else begin
            tx_start_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (drain_en && !fifo_empty) begin
                        state_reg     <= SEND;
                        tx_data_reg   <= fifo_rd_data;
                        tx_start_reg  <= 1'b1;
                        tx_active_reg <= 1'b1;
                    end
                end
                SEND: begin
                    state_reg      <= WAIT_DONE;
                    sent_count_reg <= sent_count_reg + {{CW{1'b0}}, 1'b1};
                end
                WAIT_DONE: begin
                    if (tx_done) begin
                        state_reg     <= IDLE;
                        tx_active_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    tx_active_reg <= 1'b0;
                end
            endcase
        end
    end

    assign tx_start   = tx_start_reg;
    assign fifo_read  = tx_start_reg;
    assign tx_active  = tx_active_reg;
    assign tx_data    = tx_data_reg;
    assign sent_count = sent_count_reg;

endmodule

// File: tb/tb_fifo_scheduler.sv
// Bench for fifo_scheduler: a 16-deep FIFO and UART model around the DUT, plus a
// spec-level reference for grants and drain, exercised by directed and random scenarios.
module tb_fifo_scheduler;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [7:0] req0_data = 8'h00;
    logic [7:0] req1_data = 8'h00;
    logic       gnt0, gnt1, fifo_write, fifo_read, tx_start, tx_active;
    logic [7:0] fifo_wr_data, tx_data;
    logic       fifo_full = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_rd_data = 8'h00;
    logic       drain_en = 1'b0;
    logic       tx_done;
    logic       tx_done_uart = 1'b0;
    logic       tx_done_inj = 1'b0;
    logic [15:0] sent_count;

    assign tx_done = tx_done_uart | tx_done_inj;

    fifo_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .req0         (req0),
        .req1         (req1),
        .req0_data    (req0_data),
        .req1_data    (req1_data),
        .gnt0         (gnt0),
        .gnt1         (gnt1),
        .fifo_write   (fifo_write),
        .fifo_wr_data (fifo_wr_data),
        .fifo_full    (fifo_full),
        .fifo_read    (fifo_read),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .drain_en     (drain_en),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_done      (tx_done),
        .tx_active    (tx_active),
        .sent_count   (sent_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Environment and reference state
    logic [7:0] fifo_q[$];
    int         cyc_n = 0;
    int         uart_delay = 10;
    int         done_at = 0;
    bit         uart_pending = 0;
    bit         ref_last = 1;
    bit         ref_busy = 0;
    bit         ref_send = 0;
    logic [7:0] ref_byte = 8'h00;
    logic [15:0] ref_count = 16'h0000;
    int         exp_win = -1;
    int         grant_err = 0;
    int         drain_err = 0;
    bit         obs_g0 = 0, obs_g1 = 0, obs_start = 0, obs_read = 0, obs_write = 0;
    logic [7:0] obs_wdata = 8'h00;

    // Transaction logs
    int         gnt_who[$];
    int         gnt_cyc[$];
    logic [7:0] gnt_dat[$];
    int         st_cyc[$];
    logic [7:0] st_dat[$];

    // Mid-cycle monitor: expected grant from the round-robin rule, drain outputs
    // from the reference, and transaction logging.
    always @(negedge clk) begin
        if (!reset) begin
            if (fifo_full) exp_win = -1;
            else if (req0 && req1) exp_win = ref_last ? 0 : 1;
            else if (req0) exp_win = 0;
            else if (req1) exp_win = 1;
            else exp_win = -1;
            if (gnt0 !== (exp_win == 0) || gnt1 !== (exp_win == 1) || fifo_write !== (exp_win >= 0))
                grant_err++;
            if (fifo_wr_data !== (exp_win == 0 ? req0_data : (exp_win == 1 ? req1_data : 8'h00)))
                grant_err++;
            if (tx_start !== ref_send || fifo_read !== ref_send || tx_active !== ref_busy ||
                tx_data !== ref_byte || sent_count !== ref_count)
                drain_err++;
            obs_g0 = gnt0; obs_g1 = gnt1; obs_start = tx_start;
            obs_read = fifo_read; obs_write = fifo_write; obs_wdata = fifo_wr_data;
            if (gnt0 || gnt1) begin
                gnt_who.push_back(gnt1 ? 1 : 0);
                gnt_cyc.push_back(cyc_n);
                gnt_dat.push_back(fifo_wr_data);
            end
            if (tx_start) begin
                st_cyc.push_back(cyc_n);
                st_dat.push_back(tx_data);
                $display("tx start #%0d: byte %h at cycle %0d", st_cyc.size(), tx_data, cyc_n);
            end
        end else begin
            exp_win = -1;
            obs_g0 = 0; obs_g1 = 0; obs_start = 0; obs_read = 0; obs_write = 0;
        end
    end

    // Edge updates: reference drain, UART completion timing, FIFO contents
    always @(posedge clk) begin
        cyc_n++;
        if (reset) begin
            fifo_q.delete();
            ref_last = 1; ref_busy = 0; ref_send = 0; ref_byte = 8'h00; ref_count = 16'h0000;
            uart_pending = 0;
            fifo_full <= 1'b0; fifo_empty <= 1'b1; fifo_rd_data <= 8'h00; tx_done_uart <= 1'b0;
        end else begin
            if (ref_send) begin
                ref_send = 0;
                ref_count = ref_count + 16'd1;
            end else if (!ref_busy && drain_en && fifo_q.size() > 0) begin
                ref_send = 1;
                ref_busy = 1;
                ref_byte = fifo_q[0];
            end else if (ref_busy && tx_done) begin
                ref_busy = 0;
            end
            if (exp_win == 0) ref_last = 0;
            else if (exp_win == 1) ref_last = 1;
            if (obs_start) begin
                uart_pending = 1;
                done_at = cyc_n - 1 + uart_delay;
            end
            tx_done_uart <= uart_pending && (cyc_n == done_at);
            if (uart_pending && cyc_n == done_at) uart_pending = 0;
            if (obs_read && fifo_q.size() > 0) void'(fifo_q.pop_front());
            if (obs_write && fifo_q.size() < DEPTH) fifo_q.push_back(obs_wdata);
            fifo_full    <= (fifo_q.size() == DEPTH);
            fifo_empty   <= (fifo_q.size() == 0);
            fifo_rd_data <= (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req0 = 0; req1 = 0; drain_en = 0; tx_done_inj = 0;
        reset = 1;
        repeat (2) cyc();
        reset = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (2) cyc();
        checks++;
        if ({gnt0, gnt1, fifo_write, fifo_read, tx_start, tx_active} !== 6'b0) begin
            failures++;
            $display("FAIL reset_strobes: got %b want 000000",
                     {gnt0, gnt1, fifo_write, fifo_read, tx_start, tx_active});
        end
        checks++;
        if (tx_data !== 8'h00 || fifo_wr_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_data: got tx_data=%h wr_data=%h want 00 00", tx_data, fifo_wr_data);
        end
        checks++;
        if (sent_count !== 16'h0000) begin
            failures++;
            $display("FAIL reset_count: got %0d want 0", sent_count);
        end
        reset = 0;
        cyc();
        $display("test_reset done");
    endtask

    task automatic test_single_producer();
        logic [7:0] bytes[3];
        int gb, sb, ge;
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
        do_reset();
        gb = gnt_who.size(); sb = st_cyc.size(); ge = grant_err;
        for (int i = 0; i < 3; i++) begin
            req0 = 1; req0_data = bytes[i];
            cyc();
            checks++;
            if (obs_g0 !== 1'b1 || obs_wdata !== bytes[i]) begin
                failures++;
                $display("FAIL single_write%0d: got gnt0=%b data=%h want 1 %h", i, obs_g0, obs_wdata, bytes[i]);
            end
        end
        req0 = 0;
        repeat (3) cyc();
        checks++;
        if (gnt_who.size() - gb != 3 || fifo_q.size() != 3) begin
            failures++;
            $display("FAIL single_count: got grants=%0d occupancy=%0d want 3 3", gnt_who.size() - gb, fifo_q.size());
        end
        checks++;
        if (fifo_rd_data !== 8'h11) begin
            failures++;
            $display("FAIL single_head: got %h want 11", fifo_rd_data);
        end
        checks++;
        if (st_cyc.size() != sb || grant_err != ge) begin
            failures++;
            $display("FAIL single_quiet: got starts=%0d grant_err=%0d want 0 0", st_cyc.size() - sb, grant_err - ge);
        end
        $display("test_single_producer done");
    endtask

    task automatic test_round_robin();
        int gb;
        do_reset();
        gb = gnt_who.size();
        req0 = 1; req0_data = 8'hA0;
        req1 = 1; req1_data = 8'hB0;
        repeat (20) cyc();
        checks++;
        if (gnt_who.size() - gb != DEPTH) begin
            failures++;
            $display("FAIL rr_count: got %0d grants want %0d", gnt_who.size() - gb, DEPTH);
        end
        for (int i = 0; i < DEPTH && gb + i < gnt_who.size(); i++) begin
            checks++;
            if (gnt_who[gb + i] != (i % 2) || gnt_dat[gb + i] !== ((i % 2) != 0 ? 8'hB0 : 8'hA0)) begin
                failures++;
                $display("FAIL rr_order%0d: got gnt%0d data=%h want gnt%0d", i, gnt_who[gb + i], gnt_dat[gb + i], i % 2);
            end
        end
        checks++;
        if (fifo_full !== 1'b1 || obs_g0 !== 1'b0 || obs_g1 !== 1'b0) begin
            failures++;
            $display("FAIL rr_full_block: got full=%b gnt=%b%b want 1 00", fifo_full, obs_g0, obs_g1);
        end
        $display("test_round_robin done");
    endtask

    // Continues from the full FIFO left by test_round_robin with both requests held
    task automatic test_full_pop();
        int gb, sb, sc;
        bit seen;
        gb = gnt_who.size(); sb = st_cyc.size();
        seen = 0;
        uart_delay = 30;
        drain_en = 1;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (st_cyc.size() > sb) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL full_pop_start: got no tx_start want one within 10 cycles");
        end else begin
            sc = st_cyc[sb];
            repeat (4) cyc();
            checks++;
            if (gnt_who.size() - gb != 1) begin
                failures++;
                $display("FAIL full_pop_grants: got %0d want 1", gnt_who.size() - gb);
            end else begin
                checks++;
                if (gnt_cyc[gb] != sc + 1 || gnt_who[gb] != 0) begin
                    failures++;
                    $display("FAIL full_pop_timing: got gnt%0d at cycle %0d want gnt0 at %0d", gnt_who[gb], gnt_cyc[gb], sc + 1);
                end
            end
            checks++;
            if (st_dat[sb] !== 8'hA0 || fifo_full !== 1'b1) begin
                failures++;
                $display("FAIL full_pop_state: got byte=%h full=%b want a0 1", st_dat[sb], fifo_full);
            end
        end
        drain_en = 0; req0 = 0; req1 = 0;
        $display("test_full_pop done");
    endtask

    task automatic test_back_to_back();
        int sb, c, de;
        do_reset();
        uart_delay = 10;
        req0 = 1; req0_data = 8'h5A; cyc();
        req0_data = 8'hC3; cyc();
        req0 = 0; cyc();
        sb = st_cyc.size(); de = drain_err;
        drain_en = 1; c = cyc_n;
        for (int k = 0; k < 60; k++) begin
            cyc();
            if (st_cyc.size() >= sb + 2 && tx_active === 1'b0) break;
        end
        checks++;
        if (st_cyc.size() - sb != 2) begin
            failures++;
            $display("FAIL b2b_count: got %0d starts want 2", st_cyc.size() - sb);
        end else begin
            checks++;
            if (st_dat[sb] !== 8'h5A || st_dat[sb + 1] !== 8'hC3) begin
                failures++;
                $display("FAIL b2b_data: got %h %h want 5a c3", st_dat[sb], st_dat[sb + 1]);
            end
            checks++;
            if (st_cyc[sb] != c + 1 || st_cyc[sb + 1] - st_cyc[sb] != 12) begin
                failures++;
                $display("FAIL b2b_timing: got first=%0d gap=%0d want %0d 12", st_cyc[sb], st_cyc[sb + 1] - st_cyc[sb], c + 1);
            end
        end
        checks++;
        if (sent_count !== 16'd2 || fifo_empty !== 1'b1 || drain_err != de) begin
            failures++;
            $display("FAIL b2b_end: got count=%0d empty=%b drain_err=%0d want 2 1 0", sent_count, fifo_empty, drain_err - de);
        end
        drain_en = 0;
        $display("test_back_to_back done");
    endtask

    task automatic test_spurious_done();
        int sb, de;
        do_reset();
        uart_delay = 8;
        req1 = 1; req1_data = 8'h3C; cyc();
        req1_data = 8'h96; cyc();
        req1 = 0; cyc();
        tx_done_inj = 1; cyc(); tx_done_inj = 0;
        cyc();
        checks++;
        if (tx_active !== 1'b0 || sent_count !== 16'd0) begin
            failures++;
            $display("FAIL spur_idle: got active=%b count=%0d want 0 0", tx_active, sent_count);
        end
        sb = st_cyc.size(); de = drain_err;
        drain_en = 1; cyc();
        checks++;
        if (tx_start !== 1'b1) begin
            failures++;
            $display("FAIL spur_start_latency: got tx_start=%b want 1", tx_start);
        end
        tx_done_inj = 1; cyc(); tx_done_inj = 0;
        repeat (3) cyc();
        checks++;
        if (tx_active !== 1'b1) begin
            failures++;
            $display("FAIL spur_send: got active=%b want 1", tx_active);
        end
        for (int k = 0; k < 60; k++) begin
            cyc();
            if (st_cyc.size() >= sb + 2 && tx_active === 1'b0) break;
        end
        checks++;
        if (st_cyc.size() - sb != 2) begin
            failures++;
            $display("FAIL spur_count: got %0d starts want 2", st_cyc.size() - sb);
        end else begin
            checks++;
            if (st_cyc[sb + 1] - st_cyc[sb] != 10 || st_dat[sb] !== 8'h3C || st_dat[sb + 1] !== 8'h96) begin
                failures++;
                $display("FAIL spur_seq: got gap=%0d bytes %h %h want 10 3c 96", st_cyc[sb + 1] - st_cyc[sb], st_dat[sb], st_dat[sb + 1]);
            end
        end
        checks++;
        if (drain_err != de) begin
            failures++;
            $display("FAIL spur_model: got %0d drain deviations want 0", drain_err - de);
        end
        drain_en = 0;
        $display("test_spurious_done done");
    endtask

    task automatic test_reset_mid();
        int sb;
        bit reached;
        do_reset();
        uart_delay = 4;
        for (int i = 0; i < 6; i++) begin
            req0 = 1; req0_data = 8'(i + 1);
            cyc();
        end
        req0 = 0;
        drain_en = 1;
        reached = 0;
        for (int k = 0; k < 200; k++) begin
            cyc();
            if (sent_count === 16'd5 && tx_active === 1'b1 && tx_start === 1'b0) begin
                reached = 1;
                break;
            end
        end
        checks++;
        if (!reached) begin
            failures++;
            $display("FAIL rstmid_reach: got count=%0d want 5 while waiting", sent_count);
        end
        #2;
        reset = 1;
        #1;
        checks++;
        if ({tx_active, tx_start, fifo_read} !== 3'b000 || sent_count !== 16'd0 || tx_data !== 8'h00) begin
            failures++;
            $display("FAIL rstmid_async: got strobes=%b count=%0d data=%h want 000 0 00",
                     {tx_active, tx_start, fifo_read}, sent_count, tx_data);
        end
        @(posedge clk);
        #1;
        reset = 0;
        sb = st_cyc.size();
        repeat (10) cyc();
        checks++;
        if (st_cyc.size() != sb || tx_active !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_idle: got starts=%0d active=%b want 0 0", st_cyc.size() - sb, tx_active);
        end
        req0 = 1; req0_data = 8'h77; cyc();
        req0 = 0;
        repeat (4) cyc();
        checks++;
        if (st_cyc.size() != sb + 1 || (st_cyc.size() > sb && st_dat[sb] !== 8'h77)) begin
            failures++;
            $display("FAIL rstmid_restart: got starts=%0d want 1 with byte 77", st_cyc.size() - sb);
        end
        drain_en = 0;
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        int gb, sb, ge, de, ng, ns, bad;
        bit settled;
        do_reset();
        gb = gnt_dat.size(); sb = st_dat.size(); ge = grant_err; de = drain_err;
        for (int i = 0; i < 800; i++) begin
            if (!req0 || obs_g0) begin
                req0 = ($urandom % 3) == 0;
                req0_data = 8'($urandom);
            end
            if (!req1 || obs_g1) begin
                req1 = ($urandom % 3) == 0;
                req1_data = 8'($urandom);
            end
            drain_en = ($urandom % 4) != 0;
            uart_delay = $urandom_range(6, 2);
            tx_done_inj = !uart_pending && !tx_done_uart && (($urandom % 8) == 0);
            cyc();
        end
        req0 = 0; req1 = 0; tx_done_inj = 0; drain_en = 1;
        settled = 0;
        for (int k = 0; k < 400; k++) begin
            cyc();
            if (fifo_empty === 1'b1 && tx_active === 1'b0) begin
                settled = 1;
                break;
            end
        end
        checks++;
        if (!settled) begin
            failures++;
            $display("FAIL rand_drain: got occupancy=%0d active=%b want empty and idle", fifo_q.size(), tx_active);
        end
        ng = gnt_dat.size() - gb;
        ns = st_dat.size() - sb;
        checks++;
        if (ng != ns || ng < 20) begin
            failures++;
            $display("FAIL rand_counts: got written=%0d sent=%0d want equal and >=20", ng, ns);
        end
        bad = 0;
        for (int i = 0; i < ng && i < ns; i++)
            if (gnt_dat[gb + i] !== st_dat[sb + i]) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL rand_order: got %0d out-of-order bytes want 0", bad);
        end
        checks++;
        if (grant_err != ge || drain_err != de) begin
            failures++;
            $display("FAIL rand_model: got grant_dev=%0d drain_dev=%0d want 0 0", grant_err - ge, drain_err - de);
        end
        $display("test_random done: %0d bytes written and sent", ng);
    endtask

    initial begin
        test_reset();
        test_single_producer();
        test_round_robin();
        test_full_pop();
        test_back_to_back();
        test_spurious_done();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule
